// File: rtl/parking_gate_ctrl_if.sv
// Request/response link between the gate controller and the occupancy counter.
interface parking_gate_ctrl_if;
  logic enter;
  logic exit;
  logic grant;
  logic full;

  modport master (output enter, output exit, input grant, input full);
  modport slave  (input enter, input exit, output grant, output full);
endinterface

// File: rtl/parking_gate_ctrl.sv
// Gate-side controller: debounces both lane beams, infers direction, requests
// entry/exit from the occupancy counter and drives the barrier.
module parking_gate_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int TIMEOUT   = 32,
  parameter int TW        = 6
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       beam_out,
  input  logic                       beam_in,
  parking_gate_ctrl_if.master        cnt,
  output logic                       barrier_up,
  output logic                       alarm_full,
  output logic                       busy
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, REQ_IN, REQ_OUT, REJECT, DENY,
    OPEN_IN, OPEN_OUT, REFUND_IN, REFUND_OUT
  } state_t;

  // Index 0 = outer (street) beam, index 1 = inner (lot) beam.
  logic [1:0]    pin;
  logic [1:0]    sync1_q, sync2_q, stable_q, prev_q, armed_q, vld_q;
  logic [CW-1:0] dbc_q [2];
  logic [1:0]    rise;

  assign pin = {beam_in, beam_out};

  // armed_q keeps a beam held blocked across reset from looking like a fresh
  // arrival: a request edge counts only after a real low sample was observed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      armed_q  <= '0;
      vld_q    <= '0;
      dbc_q[0] <= '0;
      dbc_q[1] <= '0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
      prev_q  <= stable_q;
      vld_q   <= {vld_q[0], 1'b1};
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (dbc_q[i] == CW'(DB_CYCLES - 1)) begin
            stable_q[i] <= sync2_q[i];
            dbc_q[i]    <= '0;
          end else begin
            dbc_q[i] <= dbc_q[i] + CW'(1);
          end
        end else begin
          dbc_q[i] <= '0;
        end
        if (vld_q[1] && !sync2_q[i]) armed_q[i] <= 1'b1;
      end
    end
  end

  assign rise = stable_q & ~prev_q & armed_q;

  state_t        state_q;
  logic          seen_q;
  logic          alarm_q;
  logic [TW-1:0] tmr_q;
  logic          clear;
  logic          far;

  assign clear = ~stable_q[0] & ~stable_q[1];
  // The beam on the far side of the barrier proves the car went through.
  assign far   = (state_q == OPEN_OUT) ? stable_q[0] : stable_q[1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      seen_q  <= 1'b0;
      alarm_q <= 1'b0;
      tmr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise[1])      state_q <= REQ_OUT;
          else if (rise[0]) state_q <= REQ_IN;
        end
        REQ_IN: begin
          seen_q <= 1'b0;
          tmr_q  <= '0;
          if (cnt.grant) begin
            state_q <= OPEN_IN;
          end else begin
            state_q <= REJECT;
            alarm_q <= cnt.full;
          end
        end
        REQ_OUT: begin
          seen_q  <= 1'b0;
          tmr_q   <= '0;
          state_q <= cnt.grant ? OPEN_OUT : DENY;
        end
        REJECT: begin
          if (!stable_q[0]) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
          end
        end
        DENY: begin
          if (!stable_q[1]) state_q <= IDLE;
        end
        OPEN_IN, OPEN_OUT: begin
          if (seen_q && clear) begin
            state_q <= IDLE;
          end else begin
            if (far) seen_q <= 1'b1;
            if (!clear) begin
              tmr_q <= '0;
            end else if (!seen_q) begin
              if (tmr_q == TW'(TIMEOUT - 1))
                state_q <= (state_q == OPEN_IN) ? REFUND_IN : REFUND_OUT;
              if (tmr_q != TW'(TIMEOUT)) tmr_q <= tmr_q + TW'(1);
            end
          end
        end
        REFUND_IN:  state_q <= IDLE;
        REFUND_OUT: state_q <= IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

  assign cnt.enter  = (state_q == REQ_IN)  || (state_q == REFUND_OUT);
  assign cnt.exit   = (state_q == REQ_OUT) || (state_q == REFUND_IN);
  assign barrier_up = (state_q == OPEN_IN) || (state_q == OPEN_OUT);
  assign alarm_full = alarm_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: acts as the occupancy counter and scoreboards
// every enter/exit pulse against the expected kind and cycle.
module tb_parking_gate_ctrl;
  localparam int DB  = 4;
  localparam int TO  = 32;
  localparam int LAT = DB + 3;

  localparam logic [1:0] K_ENTER = 2'b01;
  localparam logic [1:0] K_EXIT  = 2'b10;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic beam_out = 1'b0;
  logic beam_in  = 1'b0;
  logic grant_en = 1'b0;
  logic grant_ex = 1'b0;
  logic full_v   = 1'b0;
  logic barrier_up, alarm_full, busy;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] kind;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  parking_gate_ctrl_if cif ();
  assign cif.grant = cif.enter ? grant_en : (cif.exit ? grant_ex : 1'b0);
  assign cif.full  = full_v;

  parking_gate_ctrl #(.DB_CYCLES(DB), .TIMEOUT(TO), .TW(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .beam_out   (beam_out),
    .beam_in    (beam_in),
    .cnt        (cif),
    .barrier_up (barrier_up),
    .alarm_full (alarm_full),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_req(input logic [1:0] kind, input int dly);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc + dly;
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (cif.enter || cif.exit) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req", {30'd0, cif.exit, cif.enter}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("req_kind", {30'd0, cif.exit, cif.enter}, {30'd0, e.kind});
        check("req_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_barrier", barrier_up, 0);
    check("rst_alarm", alarm_full, 0);
    check("rst_busy", busy, 0);
    check("rst_enter", cif.enter, 0);
    check("rst_exit", cif.exit, 0);
    RST = 1'b0;
    tick(5);

    // Entry with space
    grant_en = 1'b1;
    beam_out = 1'b1;
    expect_req(K_ENTER, LAT);
    tick(LAT);
    check("t1_barrier_on_enter", barrier_up, 0);
    tick(1);
    check("t1_barrier_up", barrier_up, 1);
    tick(2);
    beam_in = 1'b1;
    tick(4);
    beam_out = 1'b0;
    tick(4);
    beam_in = 1'b0;
    tick(4);
    check("t1_still_open", barrier_up, 1);
    tick(8);
    check("t1_barrier_down", barrier_up, 0);
    check("t1_idle", busy, 0);

    // Lot full
    grant_en = 1'b0;
    full_v   = 1'b1;
    beam_out = 1'b1;
    expect_req(K_ENTER, LAT);
    tick(LAT + 2);
    check("t2_alarm", alarm_full, 1);
    check("t2_barrier", barrier_up, 0);
    check("t2_busy", busy, 1);
    full_v   = 1'b0;
    beam_out = 1'b0;
    tick(DB + 4);
    check("t2_alarm_clr", alarm_full, 0);
    check("t2_idle", busy, 0);
    tick(3);

    // Backout: granted, outer clears, inner never blocks
    grant_en = 1'b1;
    beam_out = 1'b1;
    expect_req(K_ENTER, LAT);
    tick(LAT + 3);
    beam_out = 1'b0;
    expect_req(K_EXIT, TO + DB + 2);
    tick(TO + DB + 1);
    check("t3_open_before_to", barrier_up, 1);
    tick(1);
    check("t3_barrier_refund", barrier_up, 0);
    tick(2);
    check("t3_idle", busy, 0);
    check("t3_barrier_after", barrier_up, 0);

    // Departure with both beams rising together: exit has priority
    grant_ex = 1'b1;
    beam_out = 1'b1;
    beam_in  = 1'b1;
    expect_req(K_EXIT, LAT);
    tick(LAT + 1);
    check("t4_barrier_up", barrier_up, 1);
    tick(2);
    beam_out = 1'b0;
    beam_in  = 1'b0;
    tick(DB + 4);
    check("t4_idle", busy, 0);
    check("t4_barrier_down", barrier_up, 0);

    // 3-cycle glitches on the outer beam are filtered
    for (int g = 0; g < 4; g++) begin
      beam_out = 1'b1;
      tick(DB - 1);
      beam_out = 1'b0;
      tick(3);
    end
    tick(10);
    check("t4_glitch_idle", busy, 0);

    // Exit denied by the counter
    grant_ex = 1'b0;
    beam_in  = 1'b1;
    expect_req(K_EXIT, LAT);
    tick(LAT + 2);
    check("t4_deny_busy", busy, 1);
    check("t4_deny_barrier", barrier_up, 0);
    beam_in = 1'b0;
    tick(DB + 4);
    check("t4_deny_idle", busy, 0);
    tick(3);

    // Asynchronous reset while the barrier is up
    grant_en = 1'b1;
    beam_out = 1'b1;
    expect_req(K_ENTER, LAT);
    tick(LAT + 2);
    check("t5_open", barrier_up, 1);
    #2;
    RST     = 1'b1;
    beam_in = 1'b1;
    #1;
    check("t5_rst_barrier", barrier_up, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_enter", cif.enter, 0);
    check("t5_rst_exit", cif.exit, 0);
    tick(3);
    RST = 1'b0;
    tick(20);
    check("t5_held_no_req", busy, 0);
    beam_out = 1'b0;
    beam_in  = 1'b0;
    tick(10);
    beam_out = 1'b1;
    expect_req(K_ENTER, LAT);
    tick(LAT + 2);
    check("t5_fresh_edge", barrier_up, 1);
    tick(2);

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
